// File: rtl/pulse_triggered_deserialiser_if.sv
// ============================================================================
// Module : pulse_triggered_deserialiser_if
// Desc   : Serial-link and word-output bundle for the deserialiser.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pulse_triggered_deserialiser_if #(
  parameter int WIDTH = 16
);
  logic             serial_in;
  logic             valid_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic             frame_error;
  logic [7:0]       err_count;

  modport master (
    output serial_in, valid_in,
    input  data_out, data_valid, busy, frame_error, err_count
  );

  modport slave (
    input  serial_in, valid_in,
    output data_out, data_valid, busy, frame_error, err_count
  );
endinterface

`default_nettype wire

// File: rtl/pulse_triggered_deserialiser.sv
// ============================================================================
// Module : pulse_triggered_deserialiser
// Desc   : Rebuilds WIDTH-bit words from an MSB-first serial stream with a
//          first-bit strobe. Optional macro DESER_ERRCNT_EN adds err_count.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_triggered_deserialiser #(
  parameter int WIDTH      = 16,
  parameter int BIT_CYCLES = 1
) (
  input wire                              clk,
  input wire                              rst_n,
  pulse_triggered_deserialiser_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int             BW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0]  BIT_TOP    = BW'(WIDTH - 1);
  localparam logic [7:0]     CYC_RELOAD = 8'(BIT_CYCLES - 1);
  localparam logic           HOLD_MSB   = (BIT_CYCLES > 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [7:0]       cyc_cnt;
  logic             msb_hold;
  logic             sample_edge;
  logic             start;
  logic             take_bit;
  logic             restart;
  logic             busy_c;
  logic             valid_c;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ferr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Data bits are sampled on the last clk of their period; the MSB is taken
  // on the strobe clk, so its remaining clks are skipped via msb_hold.
  always_comb begin
    state_next  = state;
    start       = 1'b0;
    take_bit    = 1'b0;
    restart     = 1'b0;
    sample_edge = (state == S_SHIFT) && !msb_hold && (cyc_cnt == 8'd0);
    case (state)
      S_IDLE: begin
        if (bus.valid_in) begin
          start      = 1'b1;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (sample_edge) begin
          if (bus.valid_in) begin
            restart = 1'b1;
          end else begin
            take_bit = 1'b1;
            if (bit_cnt == BW'(1)) begin
              state_next = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (bus.valid_in) begin
          start      = 1'b1;
          state_next = S_SHIFT;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c  = (state == S_SHIFT);
    valid_c = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      cyc_cnt  <= 8'd0;
      msb_hold <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      valid_q <= valid_c;
      ferr_q  <= restart;
      if (valid_c) begin
        data_q <= shreg;
      end
      if (start || restart) begin
        shreg    <= {{(WIDTH-1){1'b0}}, bus.serial_in};
        bit_cnt  <= BIT_TOP;
        cyc_cnt  <= CYC_RELOAD;
        msb_hold <= HOLD_MSB;
      end else if (state == S_SHIFT) begin
        if (msb_hold) begin
          if (cyc_cnt == 8'd1) begin
            msb_hold <= 1'b0;
            cyc_cnt  <= CYC_RELOAD;
          end else begin
            cyc_cnt <= cyc_cnt - 8'd1;
          end
        end else if (take_bit) begin
          shreg   <= {shreg[WIDTH-2:0], bus.serial_in};
          bit_cnt <= bit_cnt - BW'(1);
          cyc_cnt <= CYC_RELOAD;
        end else begin
          cyc_cnt <= cyc_cnt - 8'd1;
        end
      end
    end
  end

  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.busy        = busy_c;
  assign bus.frame_error = ferr_q;

`ifdef DESER_ERRCNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (restart && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.err_count = err_cnt;
`else
  assign bus.err_count = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pulse_triggered_deserialiser.sv
// ============================================================================
// Module : tb_pulse_triggered_deserialiser
// Desc   : Directed table-driven checks of the deserialiser at 1 and 4 clks/bit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_triggered_deserialiser;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   fe1;
  int   dv1;
  int   fe4;
  int   dv4;

  pulse_triggered_deserialiser_if #(.WIDTH(16)) if1 ();
  pulse_triggered_deserialiser_if #(.WIDTH(16)) if4 ();

  pulse_triggered_deserialiser #(.WIDTH(16), .BIT_CYCLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  pulse_triggered_deserialiser #(.WIDTH(16), .BIT_CYCLES(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if1.frame_error) fe1 = fe1 + 1;
    if (if1.data_valid)  dv1 = dv1 + 1;
    if (if4.frame_error) fe4 = fe4 + 1;
    if (if4.data_valid)  dv4 = dv4 + 1;
  end

  typedef struct {
    logic [15:0] word;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one 16-bit frame at one bit per clk; ends in the DONE cycle.
  task automatic frame1(input logic [15:0] w, input bit chk_prev, input logic [15:0] prev);
    for (int b = 15; b >= 0; b--) begin
      if1.valid_in  = (b == 15);
      if1.serial_in = w[b];
      step();
      if (b == 15) begin
        check("busy_first", 32'(if1.busy), 32'd1);
        if (chk_prev) begin
          check("b2b_valid", 32'(if1.data_valid), 32'd1);
          check("b2b_data", 32'(if1.data_out), 32'(prev));
        end
      end
      if (b == 0) check("busy_done", 32'(if1.busy), 32'd0);
    end
    if1.valid_in  = 1'b0;
    if1.serial_in = 1'b0;
  endtask

  initial begin
    logic [15:0] w4;
    logic [15:0] part;
    int          dv_snap;
    int          fe_snap;
    int          dv4_snap;
    int          fe4_snap;

    tests = 0; fails = 0;
    fe1 = 0; dv1 = 0; fe4 = 0; dv4 = 0;
    vecs[0] = '{16'hA5C3, 16'hA5C3};
    vecs[1] = '{16'h0000, 16'h0000};
    vecs[2] = '{16'hFFFF, 16'hFFFF};
    vecs[3] = '{16'h8001, 16'h8001};
    vecs[4] = '{16'h7FFE, 16'h7FFE};

    if1.valid_in = 1'b0; if1.serial_in = 1'b0;
    if4.valid_in = 1'b0; if4.serial_in = 1'b0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("rst_data_out", 32'(if1.data_out), 32'h0);
    check("rst_busy", 32'(if1.busy), 32'd0);
    check("rst_data_valid", 32'(if1.data_valid), 32'd0);
    check("rst_frame_error", 32'(if1.frame_error), 32'd0);
    check("rst_err_count", 32'(if1.err_count), 32'd0);
    check("rst_data_out4", 32'(if4.data_out), 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    fe1 = 0; dv1 = 0; fe4 = 0; dv4 = 0;

    // Single frames, each followed by an idle cycle
    for (int i = 0; i < 5; i++) begin
      dv_snap = dv1;
      frame1(vecs[i].word, 1'b0, 16'h0);
      check("pre_valid_low", 32'(if1.data_valid), 32'd0);
      step();
      check("tbl_valid", 32'(if1.data_valid), 32'd1);
      check("tbl_data", 32'(if1.data_out), 32'(vecs[i].exp_out));
      check("tbl_busy_after", 32'(if1.busy), 32'd0);
      step();
      check("tbl_pulse_width", 32'(if1.data_valid), 32'd0);
      check("tbl_data_held", 32'(if1.data_out), 32'(vecs[i].exp_out));
      check("tbl_one_pulse", 32'(dv1 - dv_snap), 32'd1);
    end
    check("tbl_no_ferr", 32'(fe1), 32'd0);

    // Back-to-back: second strobe lands in the DONE cycle
    dv_snap = dv1;
    frame1(16'h0001, 1'b0, 16'h0);
    frame1(16'hFFFF, 1'b1, 16'h0001);
    step();
    check("b2b_valid2", 32'(if1.data_valid), 32'd1);
    check("b2b_data2", 32'(if1.data_out), 32'hFFFF);
    step();
    check("b2b_two_pulses", 32'(dv1 - dv_snap), 32'd2);
    check("b2b_no_ferr", 32'(fe1), 32'd0);

    // Restart at bit 8: strobe on the bit-8 sample edge becomes the new MSB
    dv_snap = dv1;
    fe_snap = fe1;
    part = 16'h5A5A;
    for (int b = 15; b >= 9; b--) begin
      if1.valid_in  = (b == 15);
      if1.serial_in = part[b];
      step();
    end
    frame1(16'h1234, 1'b0, 16'h0);
    check("rst_frame_held", 32'(if1.data_out), 32'hFFFF);
`ifdef DESER_ERRCNT_EN
    check("restart_err_count", 32'(if1.err_count), 32'd1);
`else
    check("restart_err_count", 32'(if1.err_count), 32'd0);
`endif
    step();
    check("restart_valid", 32'(if1.data_valid), 32'd1);
    check("restart_data", 32'(if1.data_out), 32'h1234);
    step();
    check("restart_one_ferr", 32'(fe1 - fe_snap), 32'd1);
    check("restart_one_valid", 32'(dv1 - dv_snap), 32'd1);

    // Four clks per bit, strobe held for the whole MSB period
    dv4_snap = dv4;
    fe4_snap = fe4;
    w4 = 16'h8001;
    for (int b = 15; b >= 0; b--) begin
      for (int k = 0; k < 4; k++) begin
        if4.valid_in  = (b == 15);
        if4.serial_in = w4[b];
        step();
        if (b == 15 && k == 0) check("bc4_busy", 32'(if4.busy), 32'd1);
      end
    end
    if4.valid_in = 1'b0; if4.serial_in = 1'b0;
    check("bc4_not_yet", 32'(if4.data_valid), 32'd0);
    check("bc4_busy_done", 32'(if4.busy), 32'd0);
    step();
    check("bc4_valid", 32'(if4.data_valid), 32'd1);
    check("bc4_data", 32'(if4.data_out), 32'h8001);
    step();
    check("bc4_one_pulse", 32'(dv4 - dv4_snap), 32'd1);
    check("bc4_no_ferr", 32'(fe4 - fe4_snap), 32'd0);

    // Async reset at bit 5 after a held word
    frame1(16'hBEEF, 1'b0, 16'h0);
    step();
    check("pre_rst_data", 32'(if1.data_out), 32'hBEEF);
    part = 16'hC3C3;
    for (int b = 15; b >= 5; b--) begin
      if1.valid_in  = (b == 15);
      if1.serial_in = part[b];
      step();
    end
    if1.valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_data_out", 32'(if1.data_out), 32'h0);
    check("arst_busy", 32'(if1.busy), 32'd0);
    check("arst_data_valid", 32'(if1.data_valid), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    frame1(16'h00FF, 1'b0, 16'h0);
    step();
    check("post_rst_valid", 32'(if1.data_valid), 32'd1);
    check("post_rst_data", 32'(if1.data_out), 32'h00FF);
    check("post_rst_errcnt", 32'(if1.err_count), 32'd0);

    // 1 start followed by 300 consecutive restart violations
    if1.valid_in  = 1'b1;
    if1.serial_in = 1'b1;
    for (int i = 0; i < 301; i++) step();
    check("sat_ferr_pulse", 32'(if1.frame_error), 32'd1);
`ifdef DESER_ERRCNT_EN
    check("sat_err_count", 32'(if1.err_count), 32'd255);
`else
    check("sat_err_count", 32'(if1.err_count), 32'd0);
`endif
    check("sat_data_held", 32'(if1.data_out), 32'h00FF);
    if1.valid_in = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
